match_resp_reorder: RTL and testbench
=====================================

// Module: match_resp_reorder
// PURPOSE
//  Per-job-PE reorder buffer downstream of the match PE array. Hands out sequential 8-bit tags
//  to the job PE's match requests. Collects match responses that return out of order from any
//  match PE, keyed by tag. Releases {tag, match_len} strictly in tag-issue order.
// PARAMETERS
//  DEPTH      16                         reorder window entries; power of two, 2..128
//  IDX_W      $clog2(DEPTH)              entry index width (derived, do not override)
//  LEN_W      `MAX_MATCH_LEN_LOG2+1      match length width, from parameters.vh
// PORTS
//  clk               in   1      clock
//  rst_n             in   1      synchronous, active-low reset
//  i_alloc_valid     in   1      job PE wants a tag for a new match request
//  o_alloc_ready     out  1      window not full
//  o_alloc_tag       out  8      tag granted on alloc handshake (= tail_tag)
//  i_resp_valid      in   1      match response from match PE crossbar
//  o_resp_ready      out  1      constant 1; entries are preallocated
//  i_resp_tag        in   8      tag of the response
//  i_resp_match_len  in   LEN_W  match length of the response
//  o_out_valid       out  1      in-order result available
//  i_out_ready       in   1      consumer accepts the result
//  o_out_tag         out  8      = head_tag
//  o_out_match_len   out  LEN_W  stored length of the head entry
//  o_inflight        out  IDX_W+1  tail_tag-head_tag, mod 256
//  o_err             out  1      sticky protocol error; tied 0 without the check macro
// BEHAVIOUR
//  - State: head_tag[7:0], tail_tag[7:0], vld[DEPTH], len[DEPTH][LEN_W]. Entry index = tag[IDX_W-1:0].
//  - Reset: head=tail=0, all vld=0, o_err=0. Resulting outputs: o_alloc_ready=1, o_alloc_tag=0,
//    o_out_valid=0, o_inflight=0.
//  - Reset asserted mid-operation drops all in-flight tags; late responses arriving after reset are UB
//    (flagged when the check macro is on).
//  - Alloc: handshake when i_alloc_valid&&o_alloc_ready. tail_tag<=tail_tag+1 (8-bit wrap 255->0).
//    o_alloc_ready = (o_inflight < DEPTH).
//  - Response: on i_resp_valid, the next edge sets vld[idx]=1 and len[idx]=i_resp_match_len.
//  - Output: o_out_valid = vld[head idx] && (o_inflight != 0). Combinational from registers.
//    Response-to-output latency is one cycle; there is no bypass.
//  - Pop: handshake when o_out_valid&&i_out_ready. Clears vld[head idx]; head_tag<=head_tag+1.
//  - Output stability: while o_out_valid&&!i_out_ready, tag and len hold.
//  - Simultaneous alloc+pop: both occur; o_inflight unchanged; ready evaluated on pre-edge count.
//  - Full (inflight==DEPTH): a pop frees a slot visible next cycle. There is no same-cycle
//    alloc-through-pop when full.
//  - Response to the head entry in the pop cycle cannot pop: vld is still 0 pre-edge.
//    It becomes valid next cycle.
//  - Multiple responses per cycle: never; the crossbar serialises them.
// CONFIGURATION
//  MATCH_REORDER_CHECK_EN defined:
//    - Each response is checked for being in-window: (i_resp_tag-head_tag) mod 256 < o_inflight.
//    - It is also checked for not being a duplicate: vld[idx]==0.
//    - A failing response is dropped (no state change); o_err<=1 sticky until reset; `LOG emits a
//      message naming the tag.
//  MATCH_REORDER_CHECK_EN undefined: no checks; responses always written; o_err tied 0.
// STRUCTURE
//  - Shared package/header parameters.vh: MAX_MATCH_LEN_LOG2, NUM_JOB_PE_LOG2, TAG_W=8 constant.
//  - Single module; no sub-module. The entry array is flops. DEPTH is small and needs two read
//    ports: head readout plus the check lookup.
// TESTING
//  1. Reset, alloc 3 (tags 0,1,2); responses tag2 len5, tag0 len7, tag1 len3
//     -> out order (0,7),(1,3),(2,5); out_valid never before tag0 written+1.
//  2. DEPTH=16: alloc 16 with no responses -> o_alloc_ready=0, inflight=16.
//     Respond tag0 and pop it -> ready=1 the next cycle.
//  3. Run 300 alloc/resp/pop in-order -> tags wrap 255->0 seamlessly; out tags continuous, no loss.
//  4. Head valid, i_out_ready=0 for 5 cycles -> tag/len stable.
//     Same-cycle alloc+pop -> inflight constant.
//  5. CHECK_EN: respond tag 40 with window 0..3 -> dropped, o_err=1 sticky.
//     Duplicate response to tag1 -> dropped, len unchanged.
//  6. Assert rst_n mid-stream with 5 in flight -> next cycle out_valid=0, inflight=0, alloc_tag=0.

Source files
------------

// File: rtl/match_resp_reorder_pkg.sv
// Shared constants for the match response reorder buffer: tag width and match-length sizing.
package match_resp_reorder_pkg;
  localparam int TAG_W              = 8;
  localparam int MAX_MATCH_LEN_LOG2 = 5;
  localparam int NUM_JOB_PE_LOG2    = 2;
  localparam int LEN_W              = MAX_MATCH_LEN_LOG2 + 1;
endpackage

// File: rtl/match_resp_reorder.sv
// Reorder buffer: issues sequential tags, collects out-of-order match responses, releases in tag order.
// Optional response checking (window + duplicate, sticky o_err) is enabled by MATCH_REORDER_CHECK_EN.
module match_resp_reorder
  import match_resp_reorder_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_alloc_valid,
  output logic             o_alloc_ready,
  output logic [7:0]       o_alloc_tag,
  input  logic             i_resp_valid,
  output logic             o_resp_ready,
  input  logic [7:0]       i_resp_tag,
  input  logic [LEN_W-1:0] i_resp_match_len,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [7:0]       o_out_tag,
  output logic [LEN_W-1:0] o_out_match_len,
  output logic [IDX_W:0]   o_inflight,
  output logic             o_err
);

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [LEN_W-1:0] len_q [DEPTH];
  logic [LEN_W-1:0] len_d [DEPTH];

  logic [TAG_W-1:0] inflight_full;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] resp_idx;
  logic             alloc_fire;
  logic             pop_fire;
  logic             resp_wr;

  // Tags are 8-bit and wrap; the difference stays correct across the wrap.
  assign inflight_full = tail_q - head_q;
  assign head_idx      = head_q[IDX_W-1:0];
  assign resp_idx      = i_resp_tag[IDX_W-1:0];

  assign o_alloc_ready   = inflight_full < TAG_W'(DEPTH);
  assign o_alloc_tag     = tail_q;
  assign o_resp_ready    = 1'b1;
  assign o_out_valid     = vld_q[head_idx] && (inflight_full != '0);
  assign o_out_tag       = head_q;
  assign o_out_match_len = len_q[head_idx];
  assign o_inflight      = inflight_full[IDX_W:0];

  assign alloc_fire = i_alloc_valid && o_alloc_ready;
  assign pop_fire   = o_out_valid && i_out_ready;

`ifdef MATCH_REORDER_CHECK_EN
  logic             err_q, err_d;
  logic [TAG_W-1:0] resp_off;
  logic             resp_ok;

  assign resp_off = i_resp_tag - head_q;
  assign resp_ok  = (resp_off < inflight_full) && !vld_q[resp_idx];
  assign resp_wr  = i_resp_valid && resp_ok;
  assign err_d    = err_q || (i_resp_valid && !resp_ok);
  assign o_err    = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  always @(posedge clk) begin
    if (rst_n && i_resp_valid && !resp_ok)
      $display("match_resp_reorder: dropped response tag %0d", i_resp_tag);
  end
`else
  logic unused_resp_tag_hi;

  assign unused_resp_tag_hi = ^i_resp_tag;
  assign resp_wr            = i_resp_valid;
  assign o_err              = 1'b0;
`endif

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vld_d  = vld_q;
    len_d  = len_q;
    if (alloc_fire) tail_d = tail_q + 8'd1;
    if (pop_fire) begin
      head_d           = head_q + 8'd1;
      vld_d[head_idx]  = 1'b0;
    end
    if (resp_wr) begin
      vld_d[resp_idx] = 1'b1;
      len_d[resp_idx] = i_resp_match_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
    end
  end

  // NOTE: the length array needs no reset; an entry is only read once its vld bit is set.
  always_ff @(posedge clk) begin
    len_q <= len_d;
  end

endmodule

// File: tb/tb_match_resp_reorder.sv
// Directed self-checking bench for match_resp_reorder (DEPTH=16); honours MATCH_REORDER_CHECK_EN.
module tb_match_resp_reorder;
  import match_resp_reorder_pkg::*;

`ifdef MATCH_REORDER_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_alloc_valid = 1'b0;
  logic             o_alloc_ready;
  logic [7:0]       o_alloc_tag;
  logic             i_resp_valid = 1'b0;
  logic             o_resp_ready;
  logic [7:0]       i_resp_tag = '0;
  logic [LEN_W-1:0] i_resp_match_len = '0;
  logic             o_out_valid;
  logic             i_out_ready = 1'b0;
  logic [7:0]       o_out_tag;
  logic [LEN_W-1:0] o_out_match_len;
  logic [4:0]       o_inflight;
  logic             o_err;

  int checks = 0;
  int errors = 0;

  match_resp_reorder #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_alloc_valid(i_alloc_valid), .o_alloc_ready(o_alloc_ready), .o_alloc_tag(o_alloc_tag),
    .i_resp_valid(i_resp_valid), .o_resp_ready(o_resp_ready), .i_resp_tag(i_resp_tag),
    .i_resp_match_len(i_resp_match_len),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_tag(o_out_tag),
    .o_out_match_len(o_out_match_len), .o_inflight(o_inflight), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [7:0] tag, input logic [LEN_W-1:0] len);
    i_resp_valid = 1'b1; i_resp_tag = tag; i_resp_match_len = len;
    cycle();
    i_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    checks++; if (o_alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %b exp 1", o_alloc_ready); end
    checks++; if (o_alloc_tag !== 8'd0) begin errors++; $display("FAIL reset_alloc_tag got %0d exp 0", o_alloc_tag); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", o_out_valid); end
    checks++; if (o_inflight !== 5'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", o_inflight); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", o_err); end
    checks++; if (o_resp_ready !== 1'b1) begin errors++; $display("FAIL reset_resp_ready got %b exp 1", o_resp_ready); end
  endtask

  task automatic test_out_of_order();
    i_alloc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (o_alloc_tag !== 8'(i)) begin errors++; $display("FAIL ooo_alloc_tag got %0d exp %0d", o_alloc_tag, i); end
      cycle();
    end
    i_alloc_valid = 1'b0;
    checks++; if (o_inflight !== 5'd3) begin errors++; $display("FAIL ooo_inflight got %0d exp 3", o_inflight); end
    respond(8'd2, 6'd5);
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL ooo_no_early_valid got %b exp 0", o_out_valid); end
    i_resp_valid = 1'b1; i_resp_tag = 8'd0; i_resp_match_len = 6'd7;
    #1;
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL ooo_no_bypass got %b exp 0", o_out_valid); end
    cycle();
    i_resp_valid = 1'b0;
    checks++; if ({o_out_valid, o_out_tag, o_out_match_len} !== {1'b1, 8'd0, 6'd7})
      begin errors++; $display("FAIL ooo_out0 got v%b t%0d l%0d exp v1 t0 l7", o_out_valid, o_out_tag, o_out_match_len); end
    i_out_ready = 1'b1;
    respond(8'd1, 6'd3);
    checks++; if ({o_out_valid, o_out_tag, o_out_match_len} !== {1'b1, 8'd1, 6'd3})
      begin errors++; $display("FAIL ooo_out1 got v%b t%0d l%0d exp v1 t1 l3", o_out_valid, o_out_tag, o_out_match_len); end
    cycle();
    checks++; if ({o_out_valid, o_out_tag, o_out_match_len} !== {1'b1, 8'd2, 6'd5})
      begin errors++; $display("FAIL ooo_out2 got v%b t%0d l%0d exp v1 t2 l5", o_out_valid, o_out_tag, o_out_match_len); end
    cycle();
    i_out_ready = 1'b0;
    checks++; if ({o_out_valid, o_inflight} !== {1'b0, 5'd0})
      begin errors++; $display("FAIL ooo_drained got v%b n%0d exp v0 n0", o_out_valid, o_inflight); end
  endtask

  task automatic test_full();
    // head = tail = 3 on entry; tags 3..18 fill the window.
    i_alloc_valid = 1'b1;
    repeat (16) cycle();
    checks++; if ({o_alloc_ready, o_inflight} !== {1'b0, 5'd16})
      begin errors++; $display("FAIL full_state got r%b n%0d exp r0 n16", o_alloc_ready, o_inflight); end
    cycle();
    checks++; if ({o_inflight, o_alloc_tag} !== {5'd16, 8'd19})
      begin errors++; $display("FAIL full_blocked got n%0d t%0d exp n16 t19", o_inflight, o_alloc_tag); end
    i_alloc_valid = 1'b0;
    respond(8'd3, 6'd1);
    // Alloc offered in the pop cycle must not go through: ready is low pre-edge.
    i_alloc_valid = 1'b1; i_out_ready = 1'b1;
    cycle();
    i_alloc_valid = 1'b0; i_out_ready = 1'b0;
    checks++; if ({o_alloc_ready, o_inflight, o_alloc_tag} !== {1'b1, 5'd15, 8'd19})
      begin errors++; $display("FAIL full_pop_frees got r%b n%0d t%0d exp r1 n15 t19", o_alloc_ready, o_inflight, o_alloc_tag); end
    for (int t = 4; t < 19; t++) begin
      respond(8'(t), 6'(t));
      checks++; if ({o_out_valid, o_out_tag, o_out_match_len} !== {1'b1, 8'(t), 6'(t)})
        begin errors++; $display("FAIL full_drain got v%b t%0d l%0d exp v1 t%0d l%0d", o_out_valid, o_out_tag, o_out_match_len, t, t); end
      i_out_ready = 1'b1; cycle(); i_out_ready = 1'b0;
    end
    checks++; if (o_inflight !== 5'd0) begin errors++; $display("FAIL full_drained got %0d exp 0", o_inflight); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_tag = 8'd19;
    for (int i = 0; i < 300; i++) begin
      checks++; if (o_alloc_tag !== exp_tag) begin errors++; $display("FAIL wrap_alloc got %0d exp %0d", o_alloc_tag, exp_tag); end
      i_alloc_valid = 1'b1; cycle(); i_alloc_valid = 1'b0;
      respond(exp_tag, 6'(i));
      checks++; if ({o_out_valid, o_out_tag, o_out_match_len} !== {1'b1, exp_tag, 6'(i)})
        begin errors++; $display("FAIL wrap_out got v%b t%0d l%0d exp v1 t%0d l%0d", o_out_valid, o_out_tag, o_out_match_len, exp_tag, 6'(i)); end
      i_out_ready = 1'b1; cycle(); i_out_ready = 1'b0;
      exp_tag = exp_tag + 8'd1;
    end
    checks++; if ({o_alloc_tag, o_out_valid, o_inflight} !== {8'd63, 1'b0, 5'd0})
      begin errors++; $display("FAIL wrap_end got t%0d v%b n%0d exp t63 v0 n0", o_alloc_tag, o_out_valid, o_inflight); end
  endtask

  task automatic test_back_to_back();
    i_alloc_valid = 1'b1; cycle(); cycle(); i_alloc_valid = 1'b0;
    respond(8'd63, 6'd9);
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if ({o_out_valid, o_out_tag, o_out_match_len} !== {1'b1, 8'd63, 6'd9})
        begin errors++; $display("FAIL stall_hold got v%b t%0d l%0d exp v1 t63 l9", o_out_valid, o_out_tag, o_out_match_len); end
    end
    i_alloc_valid = 1'b1; i_out_ready = 1'b1;
    cycle();
    i_alloc_valid = 1'b0; i_out_ready = 1'b0;
    checks++; if ({o_inflight, o_alloc_tag, o_out_tag, o_out_valid} !== {5'd2, 8'd66, 8'd64, 1'b0})
      begin errors++; $display("FAIL alloc_pop got n%0d a%0d o%0d v%b exp n2 a66 o64 v0", o_inflight, o_alloc_tag, o_out_tag, o_out_valid); end
    respond(8'd65, 6'd12);
    respond(8'd64, 6'd11);
    for (int t = 64; t < 66; t++) begin
      checks++; if ({o_out_valid, o_out_tag, o_out_match_len} !== {1'b1, 8'(t), 6'(t - 53)})
        begin errors++; $display("FAIL b2b_out got v%b t%0d l%0d exp v1 t%0d l%0d", o_out_valid, o_out_tag, o_out_match_len, t, t - 53); end
      i_out_ready = 1'b1; cycle(); i_out_ready = 1'b0;
    end
  endtask

  task automatic test_check();
    // Window is 66..69; tag 106 lies far outside it.
    i_alloc_valid = 1'b1; repeat (4) cycle(); i_alloc_valid = 1'b0;
    respond(8'd106, 6'd33);
    checks++; if ({o_err, o_inflight, o_out_valid} !== {CHECK, 5'd4, 1'b0})
      begin errors++; $display("FAIL chk_window got e%b n%0d v%b exp e%b n4 v0", o_err, o_inflight, o_out_valid, CHECK); end
    respond(8'd67, 6'd4);
    respond(8'd67, 6'd9);
    respond(8'd66, 6'd2);
    checks++; if ({o_out_valid, o_out_tag, o_out_match_len} !== {1'b1, 8'd66, 6'd2})
      begin errors++; $display("FAIL chk_head got v%b t%0d l%0d exp v1 t66 l2", o_out_valid, o_out_tag, o_out_match_len); end
    i_out_ready = 1'b1; cycle(); i_out_ready = 1'b0;
    checks++; if ({o_out_valid, o_out_tag, o_out_match_len} !== {1'b1, 8'd67, (CHECK ? 6'd4 : 6'd9)})
      begin errors++; $display("FAIL chk_dup got v%b t%0d l%0d exp v1 t67 l%0d", o_out_valid, o_out_tag, o_out_match_len, CHECK ? 4 : 9); end
    i_out_ready = 1'b1; cycle(); i_out_ready = 1'b0;
    respond(8'd68, 6'd1);
    respond(8'd69, 6'd1);
    i_out_ready = 1'b1; cycle(); cycle(); i_out_ready = 1'b0;
    repeat (3) cycle();
    checks++; if ({o_err, o_inflight} !== {CHECK, 5'd0})
      begin errors++; $display("FAIL chk_sticky got e%b n%0d exp e%b n0", o_err, o_inflight, CHECK); end
  endtask

  task automatic test_reset_mid();
    i_alloc_valid = 1'b1; repeat (5) cycle(); i_alloc_valid = 1'b0;
    respond(8'd70, 6'd6);
    checks++; if ({o_out_valid, o_inflight} !== {1'b1, 5'd5})
      begin errors++; $display("FAIL mid_pre got v%b n%0d exp v1 n5", o_out_valid, o_inflight); end
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    checks++; if ({o_out_valid, o_inflight, o_alloc_tag, o_alloc_ready, o_err} !== {1'b0, 5'd0, 8'd0, 1'b1, 1'b0})
      begin errors++; $display("FAIL mid_reset got v%b n%0d t%0d r%b e%b exp v0 n0 t0 r1 e0", o_out_valid, o_inflight, o_alloc_tag, o_alloc_ready, o_err); end
    i_alloc_valid = 1'b1; cycle(); i_alloc_valid = 1'b0;
    checks++; if ({o_alloc_tag, o_inflight, o_out_valid} !== {8'd1, 5'd1, 1'b0})
      begin errors++; $display("FAIL mid_restart got t%0d n%0d v%b exp t1 n1 v0", o_alloc_tag, o_inflight, o_out_valid); end
  endtask

  initial begin
    test_reset();
    test_out_of_order();
    test_full();
    test_wrap();
    test_back_to_back();
    test_check();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
